// File: rtl/xor_vector_sequencer_if.sv
// Host-side and datapath-side signal bundle for xor_vector_sequencer.
// start is level-sampled and accepted only in IDLE; done is a one-cycle pulse; cfg writes land only while idle/done.
interface xor_vector_sequencer_if #(
  parameter int AW   = 4,
  parameter int ERRW = 8
);
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [3:0]      cfg_data;
  logic [AW:0]     num_vec;
  logic            start;
  logic            dut_comb;
  logic            dut_ff;
  logic            drv_a;
  logic            drv_b;
  logic            busy;
  logic            done;
  logic            fail;
  logic [ERRW-1:0] err_cnt;
  logic [AW-1:0]   first_fail_idx;
  logic [1:0]      state_dbg;

  modport master (
    output cfg_we, cfg_addr, cfg_data, num_vec, start, dut_comb, dut_ff,
    input  drv_a, drv_b, busy, done, fail, err_cnt, first_fail_idx, state_dbg
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, num_vec, start, dut_comb, dut_ff,
    output drv_a, drv_b, busy, done, fail, err_cnt, first_fail_idx, state_dbg
  );
endinterface

// File: rtl/xor_vector_sequencer.sv
// Plays stored {a,b} vectors into an XOR datapath, checking the combinational output
// the same cycle and the registered output one cycle later; reports errors and completion.
module xor_vector_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int ERRW  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  xor_vector_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Entry layout: {a, b, exp_comb, exp_ff}
  logic [3:0]      mem_q [DEPTH];

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   ff_idx_q, ff_idx_d;
  logic [AW-1:0]   first_fail_idx_q, first_fail_idx_d;
  logic [AW:0]     n_q, n_d;
  logic            drv_a_q, drv_a_d;
  logic            drv_b_q, drv_b_d;
  logic            fail_q, fail_d;
  logic            ff_chk_valid_q, ff_chk_valid_d;
  logic            exp_ff_q, exp_ff_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  logic [AW-1:0]   idx_inc;
  logic            last_vec;
  logic            comb_mis;
  logic            ff_mis;
  logic [1:0]      mis_inc;
  logic [ERRW:0]   err_sum;
  logic            mem_we;

  assign idx_inc  = idx_q + AW'(1);
  assign last_vec = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
  assign mem_we   = bus.cfg_we && (state_q == S_IDLE || state_q == S_DONE) &&
                    ({1'b0, bus.cfg_addr} < (AW+1)'(DEPTH));

  // Vector storage is deliberately not reset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    ff_idx_d         = ff_idx_q;
    first_fail_idx_d = first_fail_idx_q;
    n_d              = n_q;
    drv_a_d          = drv_a_q;
    drv_b_d          = drv_b_q;
    fail_d           = fail_q;
    ff_chk_valid_d   = ff_chk_valid_q;
    exp_ff_d         = exp_ff_q;
    err_cnt_d        = err_cnt_q;
    comb_mis         = 1'b0;
    ff_mis           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_cnt_d = '0;
          fail_d    = 1'b0;
          if (bus.num_vec == '0) begin
            state_d = S_DONE;
          end else begin
            n_d              = (bus.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_vec;
            first_fail_idx_d = '0;
            drv_a_d          = mem_q[0][3];
            drv_b_d          = mem_q[0][2];
            idx_d            = '0;
            ff_chk_valid_d   = 1'b0;
            state_d          = S_RUN;
          end
        end
      end
      S_RUN: begin
        comb_mis       = (bus.dut_comb != mem_q[idx_q][1]);
        ff_mis         = ff_chk_valid_q && (bus.dut_ff != exp_ff_q);
        ff_chk_valid_d = 1'b1;
        exp_ff_d       = mem_q[idx_q][0];
        ff_idx_d       = idx_q;
        if (last_vec) begin
          state_d = S_DRAIN;
        end else begin
          idx_d   = idx_inc;
          drv_a_d = mem_q[idx_inc][3];
          drv_b_d = mem_q[idx_inc][2];
        end
      end
      S_DRAIN: begin
        ff_mis         = ff_chk_valid_q && (bus.dut_ff != exp_ff_q);
        ff_chk_valid_d = 1'b0;
        state_d        = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Up to two mismatches per cycle; the ff check refers to the older vector.
    mis_inc = {1'b0, comb_mis} + {1'b0, ff_mis};
    err_sum = {1'b0, err_cnt_q} + {{(ERRW-1){1'b0}}, mis_inc};
    if (comb_mis || ff_mis) begin
      err_cnt_d = err_sum[ERRW] ? {ERRW{1'b1}} : err_sum[ERRW-1:0];
      if (!fail_q) begin
        fail_d           = 1'b1;
        first_fail_idx_d = ff_mis ? ff_idx_q : idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      ff_idx_q         <= '0;
      first_fail_idx_q <= '0;
      n_q              <= '0;
      drv_a_q          <= 1'b0;
      drv_b_q          <= 1'b0;
      fail_q           <= 1'b0;
      ff_chk_valid_q   <= 1'b0;
      exp_ff_q         <= 1'b0;
      err_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      ff_idx_q         <= ff_idx_d;
      first_fail_idx_q <= first_fail_idx_d;
      n_q              <= n_d;
      drv_a_q          <= drv_a_d;
      drv_b_q          <= drv_b_d;
      fail_q           <= fail_d;
      ff_chk_valid_q   <= ff_chk_valid_d;
      exp_ff_q         <= exp_ff_d;
      err_cnt_q        <= err_cnt_d;
    end
  end

  assign bus.drv_a          = drv_a_q;
  assign bus.drv_b          = drv_b_q;
  assign bus.busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.fail           = fail_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.first_fail_idx = first_fail_idx_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_xor_vector_sequencer.sv
// Randomized bench for xor_vector_sequencer with a behavioural XOR datapath and a
// queue-based scoreboard of per-cycle stimulus and per-run results.
module tb_xor_vector_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int ERRW  = 4;
  localparam int RW    = 1 + ERRW + 1 + AW;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   dp_mode;
  logic dp_ff;

  logic [3:0]    ref_mem [DEPTH];
  logic [AW-1:0] last_ffi;

  logic [1:0]    drv_q [$];
  logic [RW-1:0] exp_q [$];
  logic [1:0]    mon_drv;
  logic [RW-1:0] mon_res;

  xor_vector_sequencer_if #(.AW(AW), .ERRW(ERRW)) bus ();

  xor_vector_sequencer #(.DEPTH(DEPTH), .AW(AW), .ERRW(ERRW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Clock and datapath model: mode 0 correct, 1 registered output stuck at 0, 2 comb inverted
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_ff <= 1'b0;
    else        dp_ff <= bus.drv_a ^ bus.drv_b;
  end
  assign bus.dut_comb = (dp_mode == 2) ? ~(bus.drv_a ^ bus.drv_b) : (bus.drv_a ^ bus.drv_b);
  assign bus.dut_ff   = (dp_mode == 1) ? 1'b0 : dp_ff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every vector is judged on both outputs; the earliest failing index wins.
  function automatic logic [RW-1:0] model_run(input int n);
    int errs;
    int first;
    logic x, comb_obs, ff_obs;
    logic [ERRW-1:0] sat;
    logic [AW-1:0] ffi;
    errs  = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      x        = ref_mem[k][3] ^ ref_mem[k][2];
      comb_obs = (dp_mode == 2) ? ~x : x;
      ff_obs   = (dp_mode == 1) ? 1'b0 : x;
      if (comb_obs != ref_mem[k][1]) begin errs++; if (first < 0) first = k; end
      if (ff_obs != ref_mem[k][0])   begin errs++; if (first < 0) first = k; end
    end
    sat = (errs > (2**ERRW - 1)) ? ERRW'(2**ERRW - 1) : ERRW'(errs);
    ffi = (errs > 0) ? AW'(first) : '0;
    return {(n > 0), sat, (errs > 0), ffi};
  endfunction

  // Monitor: stimulus checked every busy cycle, results checked on done
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.busy) begin
        check("drv_expected_present", 32'(drv_q.size() != 0), 1);
        if (drv_q.size() != 0) begin
          mon_drv = drv_q.pop_front();
          check("drv_ab", 32'({bus.drv_a, bus.drv_b}), 32'(mon_drv));
        end
      end
      if (bus.done) begin
        check("result_expected_present", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_res = exp_q.pop_front();
          check("err_cnt", 32'(bus.err_cnt), 32'(mon_res[AW+ERRW:AW+1]));
          check("fail", 32'(bus.fail), 32'(mon_res[AW]));
          if (mon_res[RW-1]) check("first_fail_idx", 32'(bus.first_fail_idx), 32'(mon_res[AW-1:0]));
        end
      end
    end
  end

  task automatic write_entry(input int addr, input logic [3:0] data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(addr);
    bus.cfg_data = data;
    ref_mem[addr] = data;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic run_vectors(input int nv, input bit spray);
    int n, hold, lat, cyc;
    bit seen;
    logic [RW-1:0] res;
    n   = (nv > DEPTH) ? DEPTH : nv;
    res = model_run(n);
    exp_q.push_back(res);
    if (n > 0) last_ffi = res[AW-1:0];
    for (int k = 0; k < n; k++) drv_q.push_back(ref_mem[k][3:2]);
    if (n > 0) drv_q.push_back(ref_mem[n-1][3:2]);
    hold = (n > 1) ? $urandom_range(0, n - 1) : 0;
    lat  = (n == 0) ? 1 : n + 2;
    @(negedge clk);
    bus.num_vec = (AW+1)'(nv);
    bus.start   = 1'b1;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < lat + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc > hold) bus.start = 1'b0;
      if (spray && n > 0 && cyc <= n + 1) begin
        bus.cfg_we   = 1'($urandom_range(0, 1));
        bus.cfg_addr = AW'($urandom_range(0, DEPTH - 1));
        bus.cfg_data = 4'($urandom_range(0, 15));
      end else begin
        bus.cfg_we = 1'b0;
      end
      if (bus.done) begin
        seen = 1;
        check("done_latency", 32'(cyc), 32'(lat));
        check("busy_in_done", 32'(bus.busy), 0);
      end else begin
        check("busy", 32'(bus.busy), 32'(n > 0 && cyc <= n + 1));
      end
    end
    if (!seen) check("done_latency", 32'(cyc), 32'(lat));
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check("done_pulse_width", 32'(bus.done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] va, vb;
    logic x;
    checks = 0; failures = 0; dp_mode = 0; last_ffi = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.num_vec = '0; bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_drv", 32'({bus.drv_a, bus.drv_b}), 0);
    check("rst_busy_done", 32'({bus.busy, bus.done}), 0);
    check("rst_fail", 32'(bus.fail), 0);
    check("rst_err_cnt", 32'(bus.err_cnt), 0);
    check("rst_first_fail_idx", 32'(bus.first_fail_idx), 0);
    rst_n = 1'b1;

    // Directed program: index 0 is the leftmost character
    va = 9'b001100110;
    vb = 9'b010101010;
    for (int k = 0; k < 9; k++) begin
      x = va[8-k] ^ vb[8-k];
      write_entry(k, {va[8-k], vb[8-k], x, x});
    end
    for (int k = 9; k < DEPTH; k++) begin
      x = 1'($urandom_range(0, 1));
      write_entry(k, {x, 1'b1, ~x, ~x});
    end
    run_vectors(9, 0);

    write_entry(4, 4'b0010);
    run_vectors(9, 0);
    write_entry(4, 4'b0000);

    dp_mode = 1;
    run_vectors(9, 0);
    dp_mode = 0;

    run_vectors(0, 0);
    run_vectors(20, 0);

    // Asynchronous reset in the middle of a run, with a failure already latched
    dp_mode = 1;
    for (int k = 0; k < 3; k++) drv_q.push_back(ref_mem[k][3:2]);
    @(negedge clk);
    bus.num_vec = 5'd9;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_fail", 32'(bus.fail), 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_drv", 32'({bus.drv_a, bus.drv_b}), 0);
    check("midrun_rst_busy_done", 32'({bus.busy, bus.done}), 0);
    check("midrun_rst_fail", 32'(bus.fail), 0);
    check("midrun_rst_err_cnt", 32'(bus.err_cnt), 0);
    check("midrun_rst_first_fail_idx", 32'(bus.first_fail_idx), 0);
    check("midrun_drv_q_consumed", 32'(drv_q.size()), 0);
    last_ffi = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dp_mode = 0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", 32'({bus.busy, bus.done}), 0);
    end
    run_vectors(9, 0);

    // Inverted expectations saturate the counter; writes during the run must be dropped
    for (int k = 0; k < 9; k++) write_entry(k, ref_mem[k] ^ 4'b0011);
    run_vectors(9, 1);
    run_vectors(9, 0);
    for (int k = 0; k < 9; k++) write_entry(k, ref_mem[k] ^ 4'b0011);

    // Random programs, datapath faults and run lengths
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < DEPTH; k++) begin
        logic a, b;
        logic [1:0] flip;
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        flip = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        write_entry(k, {a, b, {a ^ b, a ^ b} ^ flip});
      end
      dp_mode = $urandom_range(0, 2);
      run_vectors($urandom_range(0, 20), 1'($urandom_range(0, 1)));
      dp_mode = 0;
    end

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("drv_q_drained", 32'(drv_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
